// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// The FSM encoding and the port-index width are used by the top level and by the picker.
package sdram_arb_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LINGER = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_port_arbiter_rr.sv
// Combinational round-robin picker: the first requester at or after last+1
// (wrapping at NR_PORTS) wins.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NR_PORTS = 2
) (
  input  logic [NR_PORTS-1:0] req,
  input  port_idx_t           last,
  output port_idx_t           winner,
  output logic                valid
);

  logic [PORT_IDX_W:0] w_start;
  logic [PORT_IDX_W:0] w_sum;
  logic [NR_PORTS-1:0] w_rot;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value held and no latch is inferred.
  always_comb begin
    w_start = {1'b0, last} + 4'd1;
    if (w_start >= 4'(NR_PORTS)) w_start = '0;

    // Rotating a doubled copy puts the highest-priority port at bit 0.
    w_rot = NR_PORTS'({req, req} >> w_start);

    valid = 1'b0;
    w_sum = '0;
    for (int j = 0; j < NR_PORTS; j++) begin
      if (!valid && w_rot[j]) begin
        valid = 1'b1;
        w_sum = w_start + 4'(j);
      end
    end
    if (w_sum >= 4'(NR_PORTS)) w_sum = w_sum - 4'(NR_PORTS);
    winner = w_sum[PORT_IDX_W-1:0];
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller interface among NR_PORTS Wishbone port blocks.
// Read grants linger across the gap between refill bursts.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NR_PORTS      = 2,
  parameter int LINGER_CYCLES = 8
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst,
  input  logic [NR_PORTS-1:0]    port_acc_i,
  input  logic [NR_PORTS-1:0]    port_we_i,
  input  logic [32*NR_PORTS-1:0] port_adr_i,
  input  logic [16*NR_PORTS-1:0] port_dat_i,
  input  logic [2*NR_PORTS-1:0]  port_sel_i,
  output logic [NR_PORTS-1:0]    port_ack_o,
  output logic [31:0]            port_adr_o,
  output logic [15:0]            port_dat_o,
  output logic                   acc_o,
  output logic                   we_o,
  output logic [31:0]            adr_o,
  output logic [15:0]            dat_o,
  output logic [1:0]             sel_o,
  input  logic                   ack_i,
  input  logic [31:0]            adr_i,
  input  logic [15:0]            dat_i,
  output logic [2:0]             grant_o,
  output logic                   busy_o
);

  state_t    r_state, w_state_nxt;
  port_idx_t r_grant, w_grant_nxt;
  port_idx_t r_last_grant, w_last_nxt;
  logic [3:0] r_linger_cnt, w_linger_nxt;

  port_idx_t   w_winner;
  logic        w_valid;
  logic        w_acc_g;
  logic        w_we_g;
  logic [31:0] w_adr_g;
  logic [15:0] w_dat_g;
  logic [1:0]  w_sel_g;
  logic        w_in_grant;

  rr_arbiter #(
    .NR_PORTS(NR_PORTS)
  ) u_rr (
    .req   (port_acc_i),
    .last  (r_last_grant),
    .winner(w_winner),
    .valid (w_valid)
  );

  // Select the granted port's signals.
  always_comb begin
    w_acc_g = 1'b0;
    w_we_g  = 1'b0;
    w_adr_g = '0;
    w_dat_g = '0;
    w_sel_g = '0;
    for (int n = 0; n < NR_PORTS; n++) begin
      if (r_grant == port_idx_t'(n)) begin
        w_acc_g = port_acc_i[n];
        w_we_g  = port_we_i[n];
        w_adr_g = port_adr_i[32*n +: 32];
        w_dat_g = port_dat_i[16*n +: 16];
        w_sel_g = port_sel_i[2*n +: 2];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last_grant;
    w_linger_nxt = r_linger_cnt;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_grant_nxt = w_winner;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!w_acc_g) begin
          if (w_we_g) begin
            w_last_nxt  = r_grant;
            w_state_nxt = IDLE;
          end else begin
            w_linger_nxt = '0;
            w_state_nxt  = LINGER;
          end
        end
      end
      LINGER: begin
        w_linger_nxt = r_linger_cnt + 4'd1;
        if (w_acc_g) begin
          w_state_nxt = GRANT;
        end else if (r_linger_cnt == 4'(LINGER_CYCLES-1)) begin
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= port_idx_t'(NR_PORTS-1);
      r_linger_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_linger_cnt <= w_linger_nxt;
    end
  end

  assign w_in_grant = (r_state == GRANT);
  assign acc_o      = w_in_grant & w_acc_g;
  assign we_o       = w_in_grant & w_we_g;
  assign adr_o      = w_in_grant ? w_adr_g : '0;
  assign dat_o      = w_in_grant ? w_dat_g : '0;
  assign sel_o      = w_in_grant ? w_sel_g : '0;

  // Acks keep routing during LINGER so the tail of a read burst still lands.
  always_comb begin
    port_ack_o = '0;
    if (r_state != IDLE) begin
      for (int n = 0; n < NR_PORTS; n++) begin
        if (r_grant == port_idx_t'(n)) port_ack_o[n] = ack_i;
      end
    end
  end

  assign port_adr_o = adr_i;
  assign port_dat_o = dat_i;
  assign grant_o    = r_grant;
  assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: a two-port arbiter driven from a vector table through a
// scoreboard queue, plus hand sequences and a four-port rotation instance.
module tb_sdram_port_arbiter;

  logic sdram_clk = 1'b0;
  logic sdram_rst;
  always #5 sdram_clk = ~sdram_clk;

  // Two-port instance
  logic [1:0]  acc, we;
  logic [63:0] p_adr_in;
  logic [31:0] p_dat_in;
  logic [3:0]  p_sel_in;
  logic [1:0]  pack;
  logic [31:0] port_adr_o, adr_o, adr_i;
  logic [15:0] port_dat_o, dat_o, dat_i;
  logic        acc_o, we_o, ack_i, busy_o;
  logic [1:0]  sel_o;
  logic [2:0]  grant_o;

  // Four-port instance
  logic [3:0]   acc4, we4, pack4;
  logic [127:0] p_adr_in4;
  logic [63:0]  p_dat_in4;
  logic [7:0]   p_sel_in4;
  logic [31:0]  port_adr_o4, adr_o4;
  logic [15:0]  port_dat_o4, dat_o4;
  logic         acc_o4, we_o4, ack4, busy4;
  logic [1:0]   sel_o4;
  logic [2:0]   grant4;

  sdram_port_arbiter #(.NR_PORTS(2), .LINGER_CYCLES(8)) u_dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
    .port_acc_i(acc), .port_we_i(we), .port_adr_i(p_adr_in),
    .port_dat_i(p_dat_in), .port_sel_i(p_sel_in), .port_ack_o(pack),
    .port_adr_o(port_adr_o), .port_dat_o(port_dat_o),
    .acc_o(acc_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .ack_i(ack_i), .adr_i(adr_i), .dat_i(dat_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  sdram_port_arbiter #(.NR_PORTS(4), .LINGER_CYCLES(8)) u_dut4 (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
    .port_acc_i(acc4), .port_we_i(we4), .port_adr_i(p_adr_in4),
    .port_dat_i(p_dat_in4), .port_sel_i(p_sel_in4), .port_ack_o(pack4),
    .port_adr_o(port_adr_o4), .port_dat_o(port_dat_o4),
    .acc_o(acc_o4), .we_o(we_o4), .adr_o(adr_o4), .dat_o(dat_o4), .sel_o(sel_o4),
    .ack_i(ack4), .adr_i(adr_i), .dat_i(dat_i),
    .grant_o(grant4), .busy_o(busy4)
  );

  typedef struct {
    logic [1:0] acc;
    logic [1:0] we;
    logic       ack;
    logic       e_acc;
    logic [1:0] e_ack;
    logic [2:0] e_grant;
    logic       e_busy;
    logic       fchk;   // compare we/adr/dat/sel this cycle
    logic       e_we;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;

  logic [31:0] p_adr [2];
  logic [15:0] p_dat [2];
  logic [1:0]  p_sel [2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] a, input logic [1:0] w, input logic k,
                               input logic ea, input logic [1:0] ek, input logic [2:0] eg,
                               input logic eb, input logic fc, input logic ew);
    vec_t v;
    v.acc = a; v.we = w; v.ack = k; v.e_acc = ea; v.e_ack = ek;
    v.e_grant = eg; v.e_busy = eb; v.fchk = fc; v.e_we = ew;
    return v;
  endfunction

  task automatic tick();
    @(posedge sdram_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    p_adr[0] = 32'h0000_0200; p_adr[1] = 32'h0000_0100;
    p_dat[0] = 16'h1234;      p_dat[1] = 16'hBEEF;
    p_sel[0] = 2'b01;         p_sel[1] = 2'b11;
    p_adr_in = {p_adr[1], p_adr[0]};
    p_dat_in = {p_dat[1], p_dat[0]};
    p_sel_in = {p_sel[1], p_sel[0]};
    p_adr_in4 = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
    p_dat_in4 = {16'hD3, 16'hD2, 16'hD1, 16'hD0};
    p_sel_in4 = 8'b11_10_01_11;
    acc4 = '0; we4 = '0; ack4 = 1'b0;

    // Reset state: outputs zero even with requests and an ack present.
    sdram_rst = 1'b1;
    acc = 2'b11; we = 2'b11; ack_i = 1'b1;
    adr_i = 32'hCAFE_0001; dat_i = 16'h5A5A;
    #12;
    check("rst_acc_o", acc_o, 0);
    check("rst_we_o", we_o, 0);
    check("rst_ack", pack, 0);
    check("rst_busy", busy_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_adr_o", adr_o, 0);
    check("rst_port_adr_o", port_adr_o, 32'hCAFE_0001);
    check("rst_port_dat_o", port_dat_o, 16'h5A5A);
    acc = 2'b00; we = 2'b00; ack_i = 1'b0;
    #1 sdram_rst = 1'b0;

    // acc, we, ack | acc_o, ack_o, grant, busy, fchk, we_o
    vecs.push_back(mkv(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0)); // idle
    vecs.push_back(mkv(2'b00, 2'b00, 1, 0, 2'b00, 0, 0, 1, 0)); // stray ack dropped
    vecs.push_back(mkv(2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 1, 0)); // port 1 write request
    vecs.push_back(mkv(2'b10, 2'b10, 0, 1, 2'b00, 1, 1, 1, 1)); // granted next cycle
    vecs.push_back(mkv(2'b10, 2'b10, 1, 1, 2'b10, 1, 1, 1, 1)); // ack to port 1
    vecs.push_back(mkv(2'b00, 2'b10, 0, 0, 2'b00, 1, 1, 1, 1)); // acc drops
    vecs.push_back(mkv(2'b00, 2'b10, 0, 0, 2'b00, 1, 0, 1, 0)); // back in IDLE
    vecs.push_back(mkv(2'b01, 2'b00, 0, 0, 2'b00, 1, 0, 1, 0)); // port 0 read request
    vecs.push_back(mkv(2'b01, 2'b00, 0, 1, 2'b00, 0, 1, 1, 0));
    vecs.push_back(mkv(2'b01, 2'b00, 1, 1, 2'b01, 0, 1, 1, 0)); // first burst ack
    vecs.push_back(mkv(2'b10, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0)); // drop, port 1 asks
    vecs.push_back(mkv(2'b10, 2'b00, 1, 0, 2'b01, 0, 1, 0, 0)); // LINGER, tail ack routes
    vecs.push_back(mkv(2'b10, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0));
    vecs.push_back(mkv(2'b11, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0)); // port 0 re-raises
    vecs.push_back(mkv(2'b11, 2'b00, 0, 1, 2'b00, 0, 1, 1, 0)); // grant kept at 0
    vecs.push_back(mkv(2'b10, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0)); // final drop
    for (int i = 0; i < 8; i++)
      vecs.push_back(mkv(2'b10, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0)); // 8 LINGER cycles
    vecs.push_back(mkv(2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 1, 0)); // IDLE, port 1 wins
    vecs.push_back(mkv(2'b10, 2'b10, 0, 1, 2'b00, 1, 1, 1, 1));
    vecs.push_back(mkv(2'b00, 2'b10, 0, 0, 2'b00, 1, 1, 1, 1));
    vecs.push_back(mkv(2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 1, 0));

    foreach (vecs[i]) begin
      tick();
      acc = vecs[i].acc; we = vecs[i].we; ack_i = vecs[i].ack;
      adr_i = $urandom; dat_i = 16'($urandom);
      sb.push_back(vecs[i]);
      #1;
      cur = sb.pop_front();
      check($sformatf("v%0d_acc_o", i), acc_o, cur.e_acc);
      check($sformatf("v%0d_ack_o", i), pack, cur.e_ack);
      check($sformatf("v%0d_grant", i), grant_o, cur.e_grant);
      check($sformatf("v%0d_busy", i), busy_o, cur.e_busy);
      check($sformatf("v%0d_port_adr_o", i), port_adr_o, adr_i);
      check($sformatf("v%0d_port_dat_o", i), port_dat_o, dat_i);
      if (cur.fchk) begin
        check($sformatf("v%0d_we_o", i), we_o, cur.e_we);
        check($sformatf("v%0d_adr_o", i), adr_o, cur.e_busy ? p_adr[cur.e_grant[0]] : 32'h0);
        check($sformatf("v%0d_dat_o", i), dat_o, cur.e_busy ? p_dat[cur.e_grant[0]] : 16'h0);
        check($sformatf("v%0d_sel_o", i), sel_o, cur.e_busy ? p_sel[cur.e_grant[0]] : 2'b00);
      end
    end

    // Contention after reset: port 0 first, then port 1.
    acc = 2'b00; we = 2'b00; ack_i = 1'b0;
    tick();
    sdram_rst = 1'b1;
    #2 sdram_rst = 1'b0;
    tick(); acc = 2'b11; we = 2'b11;
    #1 check("cont_idle_busy", busy_o, 0);
    tick(); #1;
    check("cont_first_grant", grant_o, 0);
    check("cont_first_acc_o", acc_o, 1);
    tick(); acc = 2'b10;
    tick(); acc = 2'b11;
    #1 check("cont_rearb_busy", busy_o, 0);
    tick(); #1;
    check("cont_second_grant", grant_o, 1);
    check("cont_second_acc_o", acc_o, 1);
    check("cont_second_adr_o", adr_o, 32'h100);

    // Asynchronous reset in the middle of a granted cycle.
    ack_i = 1'b1;
    #1 check("arst_pre_ack", pack, 2'b10);
    #1 sdram_rst = 1'b1;
    #1;
    check("arst_acc_o", acc_o, 0);
    check("arst_we_o", we_o, 0);
    check("arst_ack", pack, 0);
    check("arst_busy", busy_o, 0);
    #2 sdram_rst = 1'b0;
    ack_i = 1'b0;
    tick(); #1;
    check("arst_after_grant", grant_o, 0);
    check("arst_after_acc_o", acc_o, 1);
    acc = 2'b00;

    // Four-port rotation with every port writing continuously.
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      tick(); acc4 = 4'hF; we4 = 4'hF; ack4 = 1'b0;
      #1 check($sformatf("rot%0d_idle", k), busy4, 0);
      tick(); ack4 = 1'b1;
      #1;
      check($sformatf("rot%0d_grant", k), grant4, e);
      check($sformatf("rot%0d_acc_o", k), acc_o4, 1);
      check($sformatf("rot%0d_ack_o", k), pack4, 4'b0001 << e);
      check($sformatf("rot%0d_adr_o", k), adr_o4, 32'h1000 * e);
      tick(); ack4 = 1'b0; acc4 = 4'hF & ~(4'b0001 << e);
      #1 check($sformatf("rot%0d_drop_acc_o", k), acc_o4, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
